// File: rtl/down_sampler_if.sv
// ============================================================================
// Module   : down_sampler_if
// Brief    : Pixel-stream handshake bundle between upstream FIFO, the
//            down-sampler and its downstream consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface down_sampler_if #(
  parameter int DW = 8
) ();
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_rd_en;
  logic          valid;
  logic [DW-1:0] dout;
  logic          rd_en_down;
  logic          frame_done;

  // master drives pixels in and pops results; slave is the down-sampler
  modport master (
    output in_valid, in_data, rd_en_down,
    input  in_rd_en, valid, dout, frame_done
  );

  modport slave (
    input  in_valid, in_data, rd_en_down,
    output in_rd_en, valid, dout, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/down_sampler.sv
// ============================================================================
// Module   : down_sampler
// Brief    : 2x2 raster decimator (keeps even-row, even-column pixels) with a
//            2-entry output buffer and frame-level isolation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module down_sampler #(
  parameter int IMG_W = 40,
  parameter int IMG_H = 40,
  parameter int DW    = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  down_sampler_if.slave  bus
);

  localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_col;
  logic [c_CW-1:0] w_col_nxt;
  logic [c_RW-1:0] r_row;
  logic [c_RW-1:0] w_row_nxt;
  logic [1:0]      r_count;
  logic [DW-1:0]   r_buf0;
  logic [DW-1:0]   r_buf1;

  logic w_keep;
  logic w_last;
  logic w_consume;
  logic w_push;
  logic w_pop;
  logic w_frame_done;

  assign w_keep = ~r_col[0] & ~r_row[0];
  assign w_last = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

  // Reset gates the pop so the FIFO is never drained while held in reset.
  // Depends only on registered count, so rd_en_down never reaches in_rd_en.
  assign w_consume = rst && bus.in_valid && (r_state != S_DONE) &&
                     (!w_keep || (r_count != 2'd2));
  assign w_push    = w_consume && w_keep;
  assign w_pop     = (r_count != 2'd0) && bus.rd_en_down;

  // --------------------------------------------------------------------------
  // Frame FSM and raster position
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE, S_ACTIVE: begin
        if (w_consume) begin
          if (r_col == c_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
          w_state_nxt = w_last ? S_DONE : S_ACTIVE;
        end
      end
      S_DONE: begin
        if (r_count == 2'd0) begin
          w_frame_done = rst;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Two-entry output buffer; r_buf0 is always the head shown on dout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_buf0 <= bus.in_data;
          end else begin
            r_buf1 <= bus.in_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // On the final pop the head keeps its value so dout holds
          if (r_count == 2'd2) begin
            r_buf0 <= r_buf1;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf0 <= bus.in_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en   = w_consume;
  assign bus.valid      = (r_count != 2'd0);
  assign bus.dout       = r_buf0;
  assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire
